json_view_parser: RTL and testbench

//  Receive-side counterpart of the view JSON packer: consumes the byte stream
//  {"1":"<payload>",\n"2":"<payload>",\n"3":"<payload>"} and recovers 64-bit RGB565 words tagged with view number.

---
 rtl/json_view_parser.sv | 143 ++++++++++++++
 tb/tb_json_view_parser.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/json_view_parser.sv
// Receive-side JSON view unpacker: checks the {"1":"..",\n"2":"..",\n"3":".."} framing,
// counts raw binary payload by length and emits 64-bit words tagged with their view number.
module json_view_parser #(
  parameter int WORDS_PER_VIEW = 102400,
  parameter int NUM_VIEWS      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [1:0]  out_view,
  output logic        out_last,
  output logic        view_start,
  output logic        view_done,
  output logic        file_done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int WCW = (WORDS_PER_VIEW > 1) ? $clog2(WORDS_PER_VIEW) : 1;
  localparam logic [WCW-1:0] LAST_W = WCW'(WORDS_PER_VIEW - 1);
  localparam logic [1:0]     LAST_V = 2'(NUM_VIEWS);

  typedef enum logic [3:0] {
    S_IDLE, S_VQ1, S_VNUM, S_VQ2, S_COL, S_DQ1, S_DATA,
    S_DQ2, S_COMMA, S_NL, S_CLOSE, S_ERR
  } state_t;

  state_t           r_state;
  logic [2:0]       r_idx;
  logic [WCW-1:0]   r_wcnt;
  logic [1:0]       r_exp;
  logic [55:0]      r_asm;

  logic       w_acc;
  logic       w_hdr;
  logic       w_match;
  logic [1:0] w_code;

  // Only the byte completing a word can stall, and only while the previous word is still held.
  assign in_ready = !(r_state == S_DATA && r_idx == 3'd7 && out_valid && !out_ready);
  assign w_acc    = in_valid && in_ready;
  assign w_hdr    = !(r_state == S_IDLE || r_state == S_DATA || r_state == S_ERR);

  always_comb begin
    w_match = 1'b1;
    w_code  = 2'b01;
    case (r_state)
      S_VQ1, S_VQ2, S_DQ1, S_DQ2: w_match = (in_data == 8'h22);
      S_VNUM: begin
        w_match = (in_data == (8'h30 + {6'd0, r_exp}));
        if (in_data >= 8'h30 && in_data <= 8'h39) w_code = 2'b10;
      end
      S_COL:   w_match = (in_data == 8'h3A);
      S_COMMA: w_match = (in_data == 8'h2C);
      S_NL:    w_match = (in_data == 8'h0A);
      S_CLOSE: w_match = (in_data == 8'h7D);
      default: w_match = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_wcnt     <= '0;
      r_exp      <= '0;
      r_asm      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_view   <= '0;
      out_last   <= 1'b0;
      view_start <= 1'b0;
      view_done  <= 1'b0;
      file_done  <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
    end else begin
      view_start <= 1'b0;
      view_done  <= 1'b0;
      file_done  <= 1'b0;
      err        <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (w_acc) begin
        if (w_hdr && !w_match) begin
          // A pending output word is deliberately left alone here.
          r_state  <= S_ERR;
          err      <= 1'b1;
          err_code <= w_code;
        end else begin
          case (r_state)
            S_IDLE, S_ERR: if (in_data == 8'h7B) begin
              r_state <= S_VQ1;
              r_exp   <= 2'd1;
            end
            S_VQ1:  r_state <= S_VNUM;
            S_VNUM: r_state <= S_VQ2;
            S_VQ2:  r_state <= S_COL;
            S_COL:  r_state <= S_DQ1;
            S_DQ1: begin
              r_state    <= S_DATA;
              view_start <= 1'b1;
              r_wcnt     <= '0;
              r_idx      <= '0;
            end
            S_DATA: begin
              // Payload is binary: counted by length, never inspected.
              r_asm <= {r_asm[47:0], in_data};
              r_idx <= r_idx + 3'd1;
              if (r_idx == 3'd7) begin
                out_valid <= 1'b1;
                out_data  <= {r_asm, in_data};
                out_view  <= r_exp;
                out_last  <= (r_wcnt == LAST_W);
                r_wcnt    <= r_wcnt + 1'b1;
                if (r_wcnt == LAST_W) r_state <= S_DQ2;
              end
            end
            S_DQ2: begin
              view_done <= 1'b1;
              r_state   <= (r_exp == LAST_V) ? S_CLOSE : S_COMMA;
            end
            S_COMMA: r_state <= S_NL;
            S_NL: begin
              r_state <= S_VQ1;
              r_exp   <= r_exp + 2'd1;
            end
            S_CLOSE: begin
              file_done <= 1'b1;
              r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_json_view_parser.sv
// Directed bench for json_view_parser with WORDS_PER_VIEW=2: a file-level model builds the
// byte stream and the words it must produce; a per-cycle monitor compares the DUT against it.
module tb_json_view_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [1:0]  out_view;
  logic        out_last;
  logic        view_start, view_done, file_done, err;
  logic [1:0]  err_code;

  json_view_parser #(.WORDS_PER_VIEW(2), .NUM_VIEWS(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_view(out_view),
    .out_last(out_last), .view_start(view_start), .view_done(view_done),
    .file_done(file_done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  bq[$];
  logic [7:0]  pay [1:3][0:15];
  logic [63:0] exp_w [0:63];
  logic [1:0]  exp_v [0:63];
  logic        exp_l [0:63];
  int          exp_n = 0;
  logic [63:0] wlog [0:63];
  int          mon_n = 0;

  int c_vs = 0, c_vd = 0, c_fd = 0, c_err = 0, stalls = 0;
  int b_vs, b_vd, b_fd, b_err, b_stalls, b_n;
  logic [1:0]  last_code = 2'b00;
  bit          hold_prev = 1'b0;
  logic [63:0] p_data;
  logic [1:0]  p_view;
  logic        p_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle compare, run on the falling edge while inputs and outputs are stable.
  task automatic monitor();
    if (!rst_n) begin
      hold_prev = 1'b0;
      return;
    end
    if (hold_prev) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", out_data, p_data);
      chk("hold_view_last", {61'd0, out_view, out_last}, {61'd0, p_view, p_last});
    end
    if (out_valid && out_ready) begin
      if (mon_n < exp_n) begin
        chk("word_data", out_data, exp_w[mon_n]);
        chk("word_view_last", {61'd0, out_view, out_last}, {61'd0, exp_v[mon_n], exp_l[mon_n]});
      end else begin
        chk("extra_word", 64'(mon_n), 64'(exp_n));
      end
      if (mon_n < 64) wlog[mon_n] = out_data;
      mon_n++;
    end
    hold_prev = out_valid && !out_ready;
    p_data = out_data; p_view = out_view; p_last = out_last;
    if (view_start) c_vs++;
    if (view_done)  c_vd++;
    if (file_done)  c_fd++;
    if (err) begin c_err++; last_code = err_code; end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk); #1;
  endtask

  // hold>0: keep out_ready low for that many clocks after the first word appears.
  task automatic send(input int hold);
    int  budget = 0;
    int  seen = -1;
    bit  acc;
    while (bq.size() > 0 && budget < 4000) begin
      in_valid = 1'b1;
      in_data  = bq[0];
      @(negedge clk);
      monitor();
      acc = in_ready;
      if (!in_ready) stalls++;
      if (hold > 0 && seen < 0 && out_valid) seen = 0;
      @(posedge clk); #1;
      if (acc) void'(bq.pop_front());
      budget++;
      if (seen >= 0) begin
        seen++;
        if (seen == hold) out_ready = 1'b1;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (bq.size() > 0) begin
      chk("send_timeout", 64'(bq.size()), 64'd0);
      bq.delete();
    end
  endtask

  task automatic fill_pay(input int seed, input bit nobrace);
    logic [7:0] b;
    for (int v = 1; v <= 3; v++)
      for (int k = 0; k < 16; k++) begin
        b = 8'((seed * 7 + v * 37 + k * 11) & 255);
        if (nobrace && b == 8'h7B) b = 8'h7A;
        pay[v][k] = b;
      end
  endtask

  // Builds one file; bad_dig / bad_col name the view whose digit / colon is corrupted.
  task automatic build_file(input int bad_dig, input int bad_col);
    bit dead = 1'b0;
    bq.push_back(8'h7B);
    for (int v = 1; v <= 3; v++) begin
      if (v > 1) begin bq.push_back(8'h2C); bq.push_back(8'h0A); end
      bq.push_back(8'h22);
      bq.push_back((v == bad_dig) ? 8'(49 + v) : 8'(48 + v));
      bq.push_back(8'h22);
      bq.push_back((v == bad_col) ? 8'h3B : 8'h3A);
      bq.push_back(8'h22);
      for (int k = 0; k < 16; k++) bq.push_back(pay[v][k]);
      bq.push_back(8'h22);
      if (v == bad_dig || v == bad_col) dead = 1'b1;
      if (!dead)
        for (int w = 0; w < 2; w++) begin
          exp_w[exp_n] = {pay[v][8*w],   pay[v][8*w+1], pay[v][8*w+2], pay[v][8*w+3],
                          pay[v][8*w+4], pay[v][8*w+5], pay[v][8*w+6], pay[v][8*w+7]};
          exp_v[exp_n] = 2'(v);
          exp_l[exp_n] = (w == 1);
          exp_n++;
        end
    end
    bq.push_back(8'h7D);
  endtask

  task automatic snap();
    b_vs = c_vs; b_vd = c_vd; b_fd = c_fd; b_err = c_err; b_stalls = stalls; b_n = mon_n;
  endtask

  task automatic check_counts(input string t, input int vs, input int vd, input int fd,
                              input int er, input int words);
    chk({t, "_view_start"}, 64'(c_vs - b_vs), 64'(vs));
    chk({t, "_view_done"},  64'(c_vd - b_vd), 64'(vd));
    chk({t, "_file_done"},  64'(c_fd - b_fd), 64'(fd));
    chk({t, "_err"},        64'(c_err - b_err), 64'(er));
    chk({t, "_words"},      64'(mon_n - b_n), 64'(words));
    chk({t, "_all_words_seen"}, 64'(mon_n), 64'(exp_n));
  endtask

  initial begin
    #1;
    chk("reset_flags", {56'd0, out_valid, out_last, view_start, view_done, file_done, err, err_code},
        64'd0);
    chk("reset_view", 64'(out_view), 64'd0);
    chk("reset_data", out_data, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // 1+2: legal file, payload includes '"', '}' and '{' bytes
    fill_pay(1, 1'b0);
    for (int k = 0; k < 8; k++) pay[1][k] = 8'(k + 1);
    pay[1][8]  = 8'h22; pay[1][9]  = 8'h7D; pay[1][10] = 8'h7B; pay[1][11] = 8'h2C;
    pay[1][12] = 8'h0A; pay[1][13] = 8'h3A; pay[1][14] = 8'h22; pay[1][15] = 8'h7D;
    snap();
    build_file(0, 0);
    send(0);
    repeat (4) tick();
    check_counts("t1", 3, 3, 1, 0, 6);
    chk("t2_word0", wlog[b_n], 64'h0102030405060708);
    chk("t2_word1", wlog[b_n + 1], 64'h227D7B2C0A3A227D);

    // 3: backpressure at first word for 20 cycles
    fill_pay(3, 1'b0);
    snap();
    out_ready = 1'b0;
    build_file(0, 0);
    send(20);
    repeat (4) tick();
    check_counts("t3", 3, 3, 1, 0, 6);
    chk("t3_stall_cycles", 64'(stalls - b_stalls), 64'd13);

    // 4: wrong view digit, then a legal file
    snap();
    fill_pay(4, 1'b1);
    build_file(1, 0);
    fill_pay(5, 1'b1);
    build_file(0, 0);
    send(0);
    repeat (4) tick();
    check_counts("t4", 3, 3, 1, 1, 6);
    chk("t4_err_code", 64'(last_code), 64'd2);
    chk("t4_err_code_held", 64'(err_code), 64'd2);

    // 5: ';' in view 3 header
    snap();
    fill_pay(6, 1'b1);
    build_file(0, 3);
    send(0);
    repeat (4) tick();
    check_counts("t5", 2, 2, 0, 1, 4);
    chk("t5_err_code", 64'(last_code), 64'd1);

    // 6: reset in the middle of a word, then a fresh file
    bq = '{8'h7B, 8'h22, 8'h31, 8'h22, 8'h3A, 8'h22, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send(0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_flags", {56'd0, out_valid, out_last, view_start, view_done, file_done, err, err_code},
        64'd0);
    chk("t6_rst_data", out_data, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    snap();
    fill_pay(7, 1'b0);
    for (int k = 0; k < 8; k++) pay[1][k] = 8'(8'h11 + k);
    build_file(0, 0);
    send(0);
    repeat (4) tick();
    check_counts("t6", 3, 3, 1, 0, 6);
    chk("t6_word0", wlog[b_n], 64'h1112131415161718);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
